// File: rtl/motor_ctrl_pkg.sv
// Shared motor-control types and default constants for the encoder velocity block.
package motor_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } vel_state_t;

    localparam int DEFAULT_WINDOW_CYCLES = 50000;
    localparam int DEFAULT_STALL_WINDOWS = 8;
    localparam int DEFAULT_COUNT_W       = 16;

endpackage

// File: rtl/encoder_velocity_if.sv
// Encoder velocity bus: enable/count in from the counter stage, speed/status out.
interface encoder_velocity_if
    import motor_ctrl_pkg::*;
#(
    parameter int COUNT_W = DEFAULT_COUNT_W
);
    logic               enable;
    logic [COUNT_W-1:0] enc_count;
    logic [COUNT_W-1:0] speed;
    logic               speed_valid;
    logic               stalled;

    modport master (
        output enable, enc_count,
        input  speed, speed_valid, stalled
    );

    modport slave (
        input  enable, enc_count,
        output speed, speed_valid, stalled
    );
endinterface

// File: rtl/window_tick_gen.sv
// Measurement window counter; tick is high on the last cycle of each window.
module window_tick_gen
    import motor_ctrl_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(WINDOW_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(WINDOW_CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end
endmodule

// File: rtl/encoder_velocity.sv
// Windowed encoder speed measurement with stall detection.
// Optional 4-window moving average of speed when ENC_VEL_AVG_EN is defined.
module encoder_velocity
    import motor_ctrl_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
    parameter int COUNT_W       = DEFAULT_COUNT_W,
    parameter int STALL_WINDOWS = DEFAULT_STALL_WINDOWS
) (
    input  logic               clk,
    input  logic               reset,
    encoder_velocity_if.slave  bus
);
    localparam int ZW = $clog2(STALL_WINDOWS + 1);
    localparam logic [ZW-1:0] ZERO_SAT = ZW'(STALL_WINDOWS);

    vel_state_t state, state_next;

    logic                      tick;
    logic                      prime_tick;
    logic                      run_tick;
    logic                      enter_prime;
    logic [COUNT_W-1:0]        prev_count;
    logic signed [COUNT_W-1:0] delta;
    logic [COUNT_W-1:0]        speed_calc;
    logic [ZW-1:0]             zero_cnt;
    logic [ZW-1:0]             zero_next;
    logic [COUNT_W-1:0]        speed_r;
    logic                      speed_valid_r;
    logic                      stalled_r;

    window_tick_gen #(
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (~bus.enable),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // enable low overrides every transition, including one on a tick cycle
    always_comb begin
        state_next  = state;
        prime_tick  = 1'b0;
        run_tick    = 1'b0;
        enter_prime = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_next  = PRIME;
                    enter_prime = 1'b1;
                end
            end
            PRIME: begin
                if (tick) begin
                    state_next = RUN;
                    prime_tick = bus.enable;
                end
            end
            RUN: begin
                run_tick = tick && bus.enable;
            end
            default: state_next = IDLE;
        endcase
        if (!bus.enable) begin
            state_next = IDLE;
        end
    end

    assign delta = bus.enc_count - prev_count;

    always_comb begin
        zero_next = '0;
        if (delta == '0) begin
            zero_next = (zero_cnt == ZERO_SAT) ? zero_cnt : zero_cnt + ZW'(1);
        end
    end

`ifdef ENC_VEL_AVG_EN
    logic signed [COUNT_W-1:0] hist [3];
    logic signed [COUNT_W+1:0] sum;

    always_comb begin
        sum = {{2{delta[COUNT_W-1]}}, delta}
            + {{2{hist[0][COUNT_W-1]}}, hist[0]}
            + {{2{hist[1][COUNT_W-1]}}, hist[1]}
            + {{2{hist[2][COUNT_W-1]}}, hist[2]};
        speed_calc = COUNT_W'(sum >>> 2);
    end

    // history restarts from zeros each time a new measurement run is primed
    always_ff @(posedge clk) begin
        if (reset || enter_prime) begin
            hist[0] <= '0;
            hist[1] <= '0;
            hist[2] <= '0;
        end else if (run_tick) begin
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= delta;
        end
    end
`else
    assign speed_calc = delta;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_count    <= '0;
            zero_cnt      <= '0;
            speed_r       <= '0;
            speed_valid_r <= 1'b0;
            stalled_r     <= 1'b0;
        end else begin
            speed_valid_r <= run_tick;
            if (prime_tick || run_tick) begin
                prev_count <= bus.enc_count;
            end
            if (run_tick) begin
                speed_r   <= speed_calc;
                zero_cnt  <= zero_next;
                stalled_r <= (zero_next == ZERO_SAT);
            end
        end
    end

    assign bus.speed       = speed_r;
    assign bus.speed_valid = speed_valid_r;
    assign bus.stalled     = stalled_r;
endmodule

// File: doc/encoder_velocity.md
ENCODER_VELOCITY -- requirements
Module: encoder_velocity

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 50000, clk cycles per speed measurement window (legal range 2..2^24).
REQ-002 SHALL have parameter COUNT_W, default 16, width of the incoming encoder count and of speed.
REQ-003 SHALL have parameter STALL_WINDOWS, default 8, number of consecutive zero-delta windows before stall is flagged.
REQ-004 clk  input  1  system clock; all logic on rising edge; one clock domain only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  measurement enable; low holds the block idle.
REQ-007 enc_count  input  COUNT_W  free-running, wrapping two's-complement quadrature count from the upstream counter stage, already synchronous to clk.
REQ-008 speed  output  COUNT_W  signed counts per window; held between updates.
REQ-009 speed_valid  output  1  one-cycle pulse marking a new speed value.
REQ-010 stalled  output  1  level; motor judged stationary.

Function
REQ-011 SHALL contain a window counter 0..WINDOW_CYCLES-1; the cycle it equals WINDOW_CYCLES-1 is the window tick, after which it wraps to 0.
REQ-012 SHALL implement states IDLE, PRIME, RUN: IDLE->PRIME when enable=1; PRIME->RUN on first tick; any state->IDLE when enable=0.
REQ-013 In IDLE the window counter SHALL be held at 0; speed and stalled hold their values; speed_valid=0.
REQ-014 On the PRIME tick SHALL capture enc_count into prev_count and SHALL NOT pulse speed_valid.
REQ-015 On each RUN tick SHALL compute delta = enc_count - prev_count modulo 2^COUNT_W, interpreted signed, and update prev_count := enc_count.
REQ-016 Wrap-around SHALL be handled by the modulo subtraction alone (0xFFFE->0x0003 = +5); |true delta| >= 2^(COUNT_W-1) per window is out of spec.
REQ-017 speed and speed_valid SHALL update on the clock edge following the tick (latency 1 cycle from tick).
REQ-018 A zero-delta counter SHALL increment on each zero delta, saturate at STALL_WINDOWS, clear on nonzero delta.
REQ-019 stalled SHALL assert in the same cycle as the speed_valid whose delta brings the counter to STALL_WINDOWS, and SHALL deassert in the same cycle as the first speed_valid carrying nonzero delta.
REQ-020 enable falling on a tick cycle SHALL take priority: no speed_valid pulse, state IDLE.

Reset
REQ-021 reset SHALL force: state IDLE, window counter 0, prev_count 0, zero-delta counter 0, speed 0, speed_valid 0, stalled 0, averaging history 0.
REQ-022 reset SHALL take priority over enable and tick in the same cycle; after release a full PRIME window is required before the next speed_valid.

Configuration
REQ-023 Macro ENC_VEL_AVG_EN defined: speed SHALL be (sum of last 4 deltas) >>> 2 (arithmetic shift, COUNT_W+2-bit sum, rounds toward -inf); history cleared on entering PRIME, so the first 3 outputs average with zeros.
REQ-024 Macro ENC_VEL_AVG_EN undefined: speed SHALL equal the raw delta; no history registers; stall detection always uses raw delta.

Structure
REQ-025 State enum (IDLE/PRIME/RUN) and default WINDOW_CYCLES/STALL_WINDOWS constants SHALL live in shared package motor_ctrl_pkg.
REQ-026 Window counter/tick generation SHALL be sub-module window_tick_gen (inputs clk, reset, clear; output tick).

Verification (bench uses WINDOW_CYCLES=8, STALL_WINDOWS=3, COUNT_W=16)
REQ-027 Reset, enable=1 at cycle 0, enc_count=100 constant -> no pulse at first tick (cycle 7); speed_valid at cycle 16 with speed=0.
REQ-028 enc_count +3 per window, then -2 per window -> speed=+3 each pulse, then speed=0xFFFE (-2).
REQ-029 Wrap: prev 0xFFFE, new 0x0003 -> speed=5; prev 0x0002, new 0xFFFC -> speed=-6.
REQ-030 Three zero-delta windows -> stalled=1 on 3rd pulse; next window delta=1 -> stalled=0 on that pulse.
REQ-031 reset pulsed mid-window while RUN -> all outputs 0 next cycle; next speed_valid only after PRIME plus one window; enable dropped on tick cycle -> no pulse.
REQ-032 With ENC_VEL_AVG_EN, deltas 4,8,12,16 -> speed 1,3,6,10; without it -> 4,8,12,16.
